// File: rtl/mips_bus_memory.sv
// Word-organised RAM slave for the CPU's Avalon-style bus, with programmable wait states and byte-lane writes.
// Optional: define MIPS_BUS_MEMORY_RANDOM_WAIT_EN to add 0..3 pseudo-random extra wait states per transfer.
module mips_bus_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        bus_error
);
    localparam int               IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]      SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [CNT_W-1:0] wait_load_s;
    logic [IDX_W-1:0] idx_r;
    logic             legal_r;
    logic             dir_rd_r;
    logic [3:0]       be_r;
    logic [31:0]      wdata_r;
    logic [31:0]      readdata_r;
    logic             bus_error_r;
    logic [31:0]      offset_s;
    logic             legal_s;
    logic             req_s;
    logic             accept_s;
    logic             clash_s;
    logic             access_s;
    logic             mem_we_s;
    logic [31:0]      mem_r [DEPTH_WORDS];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int l = 0; l < 4; l++) begin
            if (lanes[l]) begin
                result[8*l +: 8] = new_word[8*l +: 8];
            end else begin
                result[8*l +: 8] = old_word[8*l +: 8];
            end
        end
        return result;
    endfunction

`ifdef MIPS_BUS_MEMORY_RANDOM_WAIT_EN
    logic [7:0] lfsr_r;

    // Free-running Fibonacci LFSR (taps 8,6,5,4) jittering the wait count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign wait_load_s = WAIT_INIT + {{(CNT_W-2){1'b0}}, lfsr_r[1:0]};
`else
    assign wait_load_s = WAIT_INIT;
`endif

    // Address decode with 32-bit modular offset from the window base
    always_comb begin
        offset_s = address - BASE_ADDR;
        req_s    = read | write;
        accept_s = 1'b0;
        clash_s  = 1'b0;
        if (state_r == S_IDLE) begin
            accept_s = read ^ write;
            clash_s  = read & write;
        end else begin
            accept_s = 1'b0;
            clash_s  = 1'b0;
        end
        if ((address[1:0] == 2'b00) && (offset_s < SPAN_BYTES)) begin
            legal_s = 1'b1;
        end else begin
            legal_s = 1'b0;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        access_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_WAIT;
                    count_nxt_s = wait_load_s;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!req_s) begin
                    state_nxt_s = S_IDLE;
                end else if (count_r != {CNT_W{1'b0}}) begin
                    count_nxt_s = count_r - CNT_W'(1);
                end else begin
                    access_s    = 1'b1;
                    state_nxt_s = S_ACK;
                end
            end
            S_ACK: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        mem_we_s = access_s & ~dir_rd_r & legal_r;
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Capture the request in IDLE; later changes on the bus are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r    <= {IDX_W{1'b0}};
            legal_r  <= 1'b0;
            dir_rd_r <= 1'b0;
            be_r     <= 4'h0;
            wdata_r  <= 32'h0;
        end else if (accept_s) begin
            idx_r    <= offset_s[IDX_W+1:2];
            legal_r  <= legal_s;
            dir_rd_r <= read;
            be_r     <= byteenable;
            wdata_r  <= writedata;
        end
    end

    // Read data and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_r  <= 32'h0;
            bus_error_r <= 1'b0;
        end else begin
            if (access_s && dir_rd_r) begin
                readdata_r <= legal_r ? mem_r[idx_r] : 32'h0;
            end
            if (clash_s || (access_s && !legal_r)) begin
                bus_error_r <= 1'b1;
            end
        end
    end

    // Storage array: deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], wdata_r, be_r);
        end
    end

    assign readdata    = readdata_r;
    assign bus_error   = bus_error_r;
    assign waitrequest = req_s && (state_r != S_ACK);

endmodule

// File: tb/tb_mips_bus_memory.sv
// Scoreboard bench for mips_bus_memory: driver pushes model-predicted responses, negedge monitor checks each ACK.
`timescale 1ns/1ps
module tb_mips_bus_memory;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 64;
    localparam int          WAITC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .bus_error(bus_error)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          stall  = 0;
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_last_rd = 32'h0;
    bit          mdl_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the memory is a plain array indexed by word offset from BASE
    function automatic bit mdl_legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 32'd4 == 32'd0) && (off < 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] mdl_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic issue(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data, input bit scramble);
        exp_t e;
        int   idx;
        bit   ok;
        bit   done;
        ok  = mdl_legal(addr);
        idx = int'((addr - BASE) / 32'd4);
        if (rd) begin
            e.data      = ok ? mdl_mem[idx] : 32'h0;
            mdl_last_rd = e.data;
        end else begin
            if (ok) mdl_mem[idx] = mdl_merge(mdl_mem[idx], data, be);
            e.data = mdl_last_rd;
        end
        if (!ok) mdl_err = 1'b1;
        e.is_rd = rd;
        e.err   = mdl_err;
        exp_q.push_back(e);
        address = addr; byteenable = be; writedata = data; read = rd; write = !rd;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!waitrequest) done = 1'b1;
            else if (scramble && n >= 1) begin
                address = $urandom; writedata = $urandom; byteenable = 4'($urandom);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ACK for addr %h within 40 cycles", addr);
            exp_q.delete();
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_addr();
        return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endfunction

    // Monitor: measures the stall and checks every completed transfer against the queue
    always @(negedge clk) begin
        if (!reset || !(read || write) || (read && write)) begin
            stall = 0;
        end else if (waitrequest) begin
            stall++;
        end else begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got ACK expected none at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.is_rd ? "rd_readdata" : "wr_readdata_hold", readdata, mon_e.data);
                chk("ack_bus_error", {31'b0, bus_error}, {31'b0, mon_e.err});
`ifdef MIPS_BUS_MEMORY_RANDOM_WAIT_EN
                checks++;
                if (stall < WAITC + 2 || stall > WAITC + 5) begin
                    errors++;
                    $display("FAIL stall_range: got %0d expected %0d..%0d", stall, WAITC + 2, WAITC + 5);
                end
`else
                chk("stall_len", 32'(stall), 32'(WAITC + 2));
`endif
            end
            stall = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = 32'h0; byteenable = 4'h0; writedata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'h0);
        chk("rst_waitrequest", {31'b0, waitrequest}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) issue(1'b0, BASE + 32'(4 * i), 4'hF, $urandom, 1'b0);
        issue(1'b1, BASE + 32'd28, 4'h0, 32'h0, 1'b0);

        // Reset in the middle of WAIT: the pending write must not land
        address = BASE; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; write = 1'b0;
        mdl_last_rd = 32'h0;
        @(negedge clk);
        chk("abort_rst_readdata", readdata, 32'h0);
        chk("abort_rst_waitrequest", {31'b0, waitrequest}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, BASE, 4'h0, 32'h0, 1'b0);

        issue(1'b0, BASE + 32'd100, 4'hF, 32'h00000009, 1'b0);
        issue(1'b1, BASE + 32'd100, 4'h0, 32'h0, 1'b0);
        chk("readback_9", readdata, 32'h00000009);

        issue(1'b0, BASE + 32'd8, 4'hF, 32'h11223344, 1'b0);
        issue(1'b0, BASE + 32'd8, 4'b0101, 32'hAABBCCDD, 1'b0);
        issue(1'b1, BASE + 32'd8, 4'h0, 32'h0, 1'b0);
        chk("lane_merge", readdata, 32'h11BB33DD);
        issue(1'b0, BASE + 32'd8, 4'h0, 32'h55555555, 1'b0);
        issue(1'b1, BASE + 32'd8, 4'hF, 32'h0, 1'b0);
        chk("be_zero_write", readdata, 32'h11BB33DD);

        idle(1);
        @(negedge clk);
        chk("idle_waitrequest", {31'b0, waitrequest}, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), rand_addr(), 4'($urandom), $urandom, 1'($urandom));
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < 50; i++) issue(1'b1, rand_addr(), 4'($urandom), 32'h0, 1'b0);

        // read and write together: flagged and stalled until one drops
        address = BASE + 32'd12; read = 1'b1; write = 1'b1;
        mdl_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("clash_waitrequest", {31'b0, waitrequest}, 32'h1);
            chk("clash_readdata_held", readdata, mdl_last_rd);
            if (k >= 1) chk("clash_bus_error", {31'b0, bus_error}, 32'h1);
        end
        @(posedge clk); #1;
        write = 1'b0;
        issue(1'b1, BASE + 32'd12, 4'h0, 32'h0, 1'b0);

        issue(1'b1, BASE + 32'd2, 4'hF, 32'h0, 1'b0);
        chk("misaligned_readdata", readdata, 32'h0);
        issue(1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'hCAFEF00D, 1'b0);
        issue(1'b1, BASE, 4'h0, 32'h0, 1'b0);
        issue(1'b0, BASE - 32'd4, 4'hF, 32'h0BADF00D, 1'b0);
        issue(1'b1, BASE + 32'(4 * (DEPTH - 1)), 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) issue(1'b1, rand_addr(), 4'h0, 32'h0, 1'b0);
        chk("bus_error_sticky", {31'b0, bus_error}, 32'h1);

        idle(3);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_bus_memory.md
Name: mips_bus_memory

Overview:
- Word-organised RAM slave on the CPU's Avalon-style memory bus, directly downstream of mips_cpu_bus.
- Serves both instruction fetches and data loads/stores with a programmable number of wait states.
- Supports byte-lane writes via byteenable and flags illegal accesses.
- Used as the memory model in all bus-level CPU benches.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 1, extra WAIT cycles before ACK; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- address  input  32  byte address from the master.
- read  input  1  read request; held by the master while waitrequest=1.
- write  input  1  write request; held by the master while waitrequest=1.
- byteenable  input  4  write lane enables; bit n enables writedata[8n+7:8n].
- writedata  input  32  store data.
- readdata  output  32  registered read word; valid while waitrequest=0 and read=1.
- waitrequest  output  1  stall to the master.
- bus_error  output  1  sticky illegal-access flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, readdata=0, bus_error=0.
  - Memory array is not cleared.
- waitrequest is combinational: (read|write) && state!=ACK. It is 0 whenever there is no request.
- States:
  - IDLE:
    - On read^write: latch address, byteenable, writedata and direction; counter=WAIT_CYCLES; go to WAIT.
    - read&write together is illegal: set bus_error, stay in IDLE, keep waitrequest=1 until one drops.
  - WAIT:
    - If read|write drops to 0, the request is aborted: go to IDLE, no write is performed.
    - Else if counter!=0: decrement counter.
    - Else (counter==0): perform the access on the latched values and go to ACK.
      - Read: readdata <= mem[index].
      - Write: update only the enabled lanes.
  - ACK:
    - waitrequest=0; the transfer completes on this edge.
    - Return to IDLE unconditionally.
    - readdata holds its value until the next read completes.
- Latency: request seen in cycle 0 → ACK in cycle WAIT_CYCLES+2; waitrequest is high for WAIT_CYCLES+2 cycles.
- Back-to-back requests: ACK → IDLE costs one cycle. A request still held in IDLE is accepted as a new transfer.
- Address decode:
  - index = (address - BASE_ADDR) >> 2, 32-bit modular subtraction.
  - Legal iff address[1:0]==0 and (address - BASE_ADDR) < 4*DEPTH_WORDS.
  - Illegal: full handshake still runs; read returns 0; write is suppressed; bus_error <= 1.
- Address or data changing mid-WAIT is ignored; the values latched in IDLE are used.
- byteenable==0 on a write: completes normally and leaves memory unchanged.
- byteenable is ignored on reads; the full word is returned.
- bus_error clears only on reset.
- Reset asserted mid-transfer: aborts immediately; a pending write is not performed.

Optional Feature:
- Macro: MIPS_BUS_MEMORY_RANDOM_WAIT_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded to 8'hA5 on reset.
  - LFSR advances every cycle.
  - On IDLE accept, counter = WAIT_CYCLES + lfsr[1:0], giving WAIT_CYCLES..WAIT_CYCLES+3 extra waits.
- Undefined: counter = WAIT_CYCLES exactly; no LFSR logic is present.

Test Plan:
- Reset low mid-WAIT of a write of 32'hDEADBEEF to BASE_ADDR → reset deasserted, read of BASE_ADDR returns the old value. Before that, check readdata=0, bus_error=0, waitrequest=0 while reset=0.
- WAIT_CYCLES=1, write 32'h00000009 to BASE_ADDR+100, byteenable=4'hF → waitrequest high 3 cycles then 0 for one cycle; subsequent read returns 32'h00000009.
- Word 32'h11223344 present, write 32'hAABBCCDD with byteenable=4'b0101 → read returns 32'h11BB33DD.
- Read address BASE_ADDR+2 (misaligned) → handshake completes, readdata=0, bus_error=1 and stays 1. Write to BASE_ADDR+4*DEPTH_WORDS → memory unchanged.
- read=1 and write=1 asserted together → bus_error=1, waitrequest held 1, no state change. Then drop write → normal read completes.
- WAIT_CYCLES=0, read then immediate read of BASE_ADDR and BASE_ADDR+4 → each sees waitrequest high 2 cycles; data matches preload. With MIPS_BUS_MEMORY_RANDOM_WAIT_EN, stall lengths fall in 2..5 cycles over 50 reads.
